// File: rtl/disp_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_mux_pkg
// Description : Shared constants and scan state encoding for disp_scan_mux.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_scan_mux_pkg;

    localparam int DIGIT_W = 4;

    // Sliced down to NUM_DIGITS by the users; 8 is the widest legal display.
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage : disp_scan_mux_pkg
`default_nettype wire

// File: rtl/disp_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_mux_if
// Description : Host-side load/enable bus and display-side outputs of the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface disp_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    import disp_scan_mux_pkg::*;

    logic                            enable;
    logic                            load;
    logic [DIGIT_W*NUM_DIGITS-1:0]   data_in;
    logic [NUM_DIGITS-1:0]           dp_in;
    logic [DIGIT_W-1:0]              bi_digit;
    logic [NUM_DIGITS-1:0]           an;
    logic                            dp;
    logic                            frame_done;

    modport master (
        output enable, load, data_in, dp_in,
        input  bi_digit, an, dp, frame_done
    );

    modport slave (
        input  enable, load, data_in, dp_in,
        output bi_digit, an, dp, frame_done
    );

endinterface : disp_scan_mux_if
`default_nettype wire

// File: rtl/disp_scan_mux_scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : scan_tick_gen
// Description : DIV-cycle prescaler with synchronous clear; one-cycle tick out.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int DIV   = 50000,
    parameter int DIV_W = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    output logic      o_tick
);

    localparam logic [DIV_W-1:0] C_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == C_LAST);
    assign o_tick = w_last && !i_clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : scan_tick_gen
`default_nettype wire

// File: rtl/disp_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_mux
// Description : Tear-free N-digit common-anode 7-segment scanner feeding bin_7seg.
//               Optional macro DISP_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_mux
    import disp_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int DIV_W      = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    disp_scan_mux_if.slave   bus
);

    localparam int                IDX_W      = $clog2(NUM_DIGITS);
    localparam int                DATA_W     = DIGIT_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic [DATA_W-1:0]       r_shadow, r_display, w_display_nxt;
    logic [NUM_DIGITS-1:0]   r_dp_shadow, r_dp_reg, w_dp_reg_nxt;
    logic                    r_pending, w_pending_nxt;
    logic                    w_clear, w_tick, w_boundary, w_apply;
    logic [NUM_DIGITS-1:0]   w_lit;
    logic [NUM_DIGITS-1:0]   r_an, w_an_nxt;
    logic [DIGIT_W-1:0]      r_bi, w_bi_nxt;
    logic                    r_dp, w_dp_nxt;
    logic                    r_frame_done;

    // Prescaler holds at zero on the IDLE->SCAN edge so digit 0 gets a full slot.
    assign w_clear = !(bus.enable && (r_state == ST_SCAN));

    scan_tick_gen #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    assign w_boundary = w_tick && (r_idx == C_LAST_IDX);
    assign w_apply    = (r_state == ST_IDLE) || w_boundary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_display_nxt = r_display;
        w_dp_reg_nxt  = r_dp_reg;
        w_pending_nxt = r_pending;

        case (r_state)
            ST_IDLE: begin
                w_idx_nxt = '0;
                if (bus.enable) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!bus.enable) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else if (w_tick) begin
                    w_idx_nxt = (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase

        // A load landing on the wrap edge bypasses the shadow entirely.
        if (w_boundary && bus.load) begin
            w_display_nxt = bus.data_in;
            w_dp_reg_nxt  = bus.dp_in;
            w_pending_nxt = 1'b0;
        end else begin
            if (w_apply && r_pending) begin
                w_display_nxt = r_shadow;
                w_dp_reg_nxt  = r_dp_shadow;
                w_pending_nxt = 1'b0;
            end
            if (bus.load) begin
                w_pending_nxt = 1'b1;
            end
        end
    end

`ifdef DISP_LEADING_ZERO_BLANK_EN
    logic w_seen;

    always_comb begin
        w_lit    = '0;
        w_lit[0] = 1'b1;
        w_seen   = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (w_display_nxt[k*DIGIT_W +: DIGIT_W] != '0) begin
                w_seen = 1'b1;
            end
            w_lit[k] = w_seen || w_dp_reg_nxt[k];
        end
    end
`else
    assign w_lit = '1;
`endif

    // Outputs are computed from next-cycle idx/display so they switch on the same edge.
    always_comb begin
        w_an_nxt = ANODE_OFF[NUM_DIGITS-1:0];
        w_dp_nxt = 1'b1;
        w_bi_nxt = w_display_nxt[int'(w_idx_nxt)*DIGIT_W +: DIGIT_W];
        if (w_state_nxt == ST_SCAN) begin
            if (w_lit[w_idx_nxt]) begin
                w_an_nxt[w_idx_nxt] = 1'b0;
            end
            w_dp_nxt = ~w_dp_reg_nxt[w_idx_nxt];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= '0;
            r_shadow     <= '0;
            r_dp_shadow  <= '0;
            r_display    <= '0;
            r_dp_reg     <= '0;
            r_pending    <= 1'b0;
            r_an         <= ANODE_OFF[NUM_DIGITS-1:0];
            r_bi         <= '0;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_idx <= w_idx_nxt;
            if (bus.load) begin
                r_shadow    <= bus.data_in;
                r_dp_shadow <= bus.dp_in;
            end
            r_display    <= w_display_nxt;
            r_dp_reg     <= w_dp_reg_nxt;
            r_pending    <= w_pending_nxt;
            r_an         <= w_an_nxt;
            r_bi         <= w_bi_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.an         = r_an;
    assign bus.bi_digit   = r_bi;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frame_done;

endmodule : disp_scan_mux
`default_nettype wire

// File: doc/disp_scan_mux.md
Name: disp_scan_mux

Overview:
- Time-multiplexed scanner for an N-digit common-anode 7-segment display.
- Holds a packed hex value and rotates one digit at a time onto a shared 4-bit digit bus.
- The 4-bit digit bus feeds the existing bin_7seg decoder directly downstream.
- Drives active-low digit anodes and decimal point; new values are applied only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- DIV, 50000, clock cycles each digit stays lit (>=2).
- DIV_W, 16, prescaler width; must satisfy 2**DIV_W >= DIV.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; low blanks all digits.
- load  in  1  one-cycle strobe; captures data_in and dp_in.
- data_in  in  4*NUM_DIGITS  packed hex digits; digit k = data_in[4k+3:4k].
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
- bi_digit  out  4  current digit value, to bin_7seg.
- an  out  NUM_DIGITS  anode select, active-low, one-hot-low while scanning.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit N-1 to digit 0.

Behaviour:
- Reset values: an=all 1s, bi_digit=0, dp=1, frame_done=0, prescaler=0, idx=0, display reg=0, shadow reg=0, pending=0.
- Reset is asynchronous: outputs take reset values immediately, with no clock edge needed.
- States: IDLE (enable=0) and SCAN (enable=1). Transitions are sampled at the clock edge.
- IDLE behaviour:
  - an all 1s, dp=1, prescaler=0, idx=0.
  - If pending, shadow copies to the display reg every cycle and pending clears.
- IDLE->SCAN: on the first edge with enable=1, outputs show digit 0 (an[0]=0).
- SCAN counting:
  - The prescaler counts 0..DIV-1.
  - At the edge where prescaler==DIV-1: prescaler->0 and idx->(idx+1) mod NUM_DIGITS.
  - an, bi_digit and dp are registered and updated on that same edge from the new idx, so each digit is lit exactly DIV cycles.
- Output mapping: an[idx]=0, others 1; bi_digit=display[4idx+3:4idx]; dp=~dp_reg[idx].
- Load:
  - load writes data_in/dp_in to shadow and sets pending.
  - Back-to-back loads overwrite shadow; the last one wins.
- Frame boundary (the idx N-1 -> 0 edge):
  - If pending, shadow -> display reg and pending clears.
  - frame_done is high for exactly the following cycle.
- Load on the same cycle as the boundary edge: the incoming data_in is applied directly at that boundary and pending ends at 0.
- SCAN->IDLE: enable=0 mid-frame blanks on the next edge; idx restarts at 0 on re-enable; no frame_done is issued.
- The display reg is never written mid-frame.

Optional Feature:
- Macro: DISP_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant non-zero digit of the display reg keep their anode high during their slot.
  - The slot timing is unchanged.
  - Digit 0 is always lit, so 0 shows as a single "0".
  - A digit with its dp set is never blanked.
- Not defined: all digits are always lit while scanning.

Decomposition:
- Shared package/include holds:
  - ANODE_OFF (all-ones pattern).
  - The DIGIT_W=4 constant.
  - The scan state encoding (ST_IDLE, ST_SCAN).
- Sub-module scan_tick_gen: DIV-cycle prescaler with clear input, emitting a one-cycle tick.
- Everything else (shadow/pending, idx, output registers) lives in disp_scan_mux.

Test Plan (NUM_DIGITS=4, DIV=4):
- Reset asserted between edges -> an=4'b1111, dp=1, frame_done=0 immediately. Release with enable=0 -> outputs unchanged.
- load 16'h12AB with enable=0, then enable=1 -> repeating frame:
  - an=1110/bi_digit=B for 4 cycles.
  - 1101/A, 1011/2, 0111/1.
  - frame_done pulses once per 16 cycles.
- Displaying 16'h1234; load 16'h5678 during the digit-1 slot:
  - Rest of frame shows 2, 1.
  - Next frame shows 8, 7, 6, 5.
- load 16'hBEEF with dp_in=4'b0100 on the boundary edge cycle -> next frame shows F, E, E, B, with dp=0 only while an=1011.
- enable=0 during the digit-2 slot -> an=1111 on the next edge. enable=1 -> restart at an=1110 with no frame_done.
- With DISP_LEADING_ZERO_BLANK_EN:
  - 16'h0045 -> an[3:2] never 0.
  - 16'h0000 -> only an[0] ever 0, showing 0.
  - 16'h0045 with dp_in=4'b1000 -> an[3] lit, showing 0.
